// File: rtl/regfile_pkg.sv
// Shared defaults and types for the multi-port register file.
package regfile_pkg;

    localparam int DWIDTH_DEF = 32;
    localparam int RWIDTH_DEF = 6;
    localparam int NREAD_MAX  = 4;

    typedef logic [DWIDTH_DEF-1:0] word_t;
    typedef logic [RWIDTH_DEF-1:0] raddr_t;

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port of regfile_mp: address mux, zero-register masking, output flops.
// Optional same-cycle write bypass is enabled with `define REGFILE_BYPASS_EN.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DWIDTH   = DWIDTH_DEF,
    parameter int RWIDTH   = RWIDTH_DEF,
    parameter int ZERO_REG = 1,
    parameter int DEPTH    = 2**RWIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      re,
    input  logic [RWIDTH-1:0]         ra,
    input  logic [DEPTH*DWIDTH-1:0]   mem_flat,
    input  logic [DEPTH-1:0]          pend,
    input  logic                      we,
    input  logic [RWIDTH-1:0]         wa,
    input  logic [DWIDTH-1:0]         wd,
    input  logic                      rsv_en,
    input  logic [RWIDTH-1:0]         rsv_a,
    output logic [DWIDTH-1:0]         rd,
    output logic                      rd_pend
);

    logic [DWIDTH-1:0] rd_nxt;
    logic              pend_nxt;

    always_comb begin
        rd_nxt   = mem_flat[ra*DWIDTH +: DWIDTH];
        pend_nxt = pend[ra];
`ifdef REGFILE_BYPASS_EN
        // A reserve in the same cycle as the write leaves the register pending.
        if (we && (wa == ra)) begin
            rd_nxt   = wd;
            pend_nxt = rsv_en && (rsv_a == ra);
        end
`endif
        if ((ZERO_REG != 0) && (ra == '0)) begin
            rd_nxt   = '0;
            pend_nxt = 1'b0;
        end
    end

`ifndef REGFILE_BYPASS_EN
    logic unused_bypass;
    assign unused_bypass = ^{we, wa, wd, rsv_en, rsv_a};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd      <= '0;
            rd_pend <= 1'b0;
        end else if (re) begin
            rd      <= rd_nxt;
            rd_pend <= pend_nxt;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with registered reads, hardwired zero register and pending scoreboard.
// Build with `define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DWIDTH   = DWIDTH_DEF,
    parameter int RWIDTH   = RWIDTH_DEF,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREAD-1:0]         re,
    input  logic [NREAD*RWIDTH-1:0]  ra,
    output logic [NREAD*DWIDTH-1:0]  rd,
    output logic [NREAD-1:0]         rd_pend,
    input  logic                     we,
    input  logic [RWIDTH-1:0]        wa,
    input  logic [DWIDTH-1:0]        wd,
    input  logic                     rsv_en,
    input  logic [RWIDTH-1:0]        rsv_a
);

    localparam int DEPTH = 2**RWIDTH;

    if ((NREAD < 1) || (NREAD > NREAD_MAX)) begin : g_bad_nread
        $error("regfile_mp: NREAD out of range");
    end

    logic [DWIDTH-1:0]       mem [DEPTH];
    logic [DEPTH-1:0]        pend;
    logic [DEPTH*DWIDTH-1:0] mem_flat;
    logic                    wr_ok;
    logic                    rsv_ok;

    always_comb begin
        wr_ok  = we;
        rsv_ok = rsv_en;
        if ((ZERO_REG != 0) && (wa == '0)) wr_ok = 1'b0;
        if ((ZERO_REG != 0) && (rsv_a == '0)) rsv_ok = 1'b0;
    end

    // Reserve is applied after the write so it wins on a shared address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            pend <= '0;
        end else begin
            if (wr_ok) begin
                mem[wa]  <= wd;
                pend[wa] <= 1'b0;
            end
            if (rsv_ok) pend[rsv_a] <= 1'b1;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign mem_flat[g*DWIDTH +: DWIDTH] = mem[g];
    end

    for (genvar p = 0; p < NREAD; p++) begin : g_port
        regfile_read_port #(
            .DWIDTH   (DWIDTH),
            .RWIDTH   (RWIDTH),
            .ZERO_REG (ZERO_REG),
            .DEPTH    (DEPTH)
        ) u_port (
            .clk      (clk),
            .rst_n    (rst_n),
            .re       (re[p]),
            .ra       (ra[p*RWIDTH +: RWIDTH]),
            .mem_flat (mem_flat),
            .pend     (pend),
            .we       (we),
            .wa       (wa),
            .wd       (wd),
            .rsv_en   (rsv_en),
            .rsv_a    (rsv_a),
            .rd       (rd[p*DWIDTH +: DWIDTH]),
            .rd_pend  (rd_pend[p])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus random traffic against an array model.
module tb_regfile_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [1:0]  re_a;
    logic [11:0] ra_a;
    logic [63:0] rd_a;
    logic [1:0]  rd_pend_a;
    logic        we_a;
    logic [5:0]  wa_a;
    logic [31:0] wd_a;
    logic        rsv_en_a;
    logic [5:0]  rsv_a_a;

    logic [3:0]  re_b;
    logic [15:0] ra_b;
    logic [63:0] rd_b;
    logic [3:0]  rd_pend_b;
    logic        we_b;
    logic [3:0]  wa_b;
    logic [15:0] wd_b;
    logic        rsv_en_b;
    logic [3:0]  rsv_a_b;

    regfile_mp #(.DWIDTH(32), .RWIDTH(6), .NREAD(2), .ZERO_REG(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .re(re_a), .ra(ra_a), .rd(rd_a), .rd_pend(rd_pend_a),
        .we(we_a), .wa(wa_a), .wd(wd_a), .rsv_en(rsv_en_a), .rsv_a(rsv_a_a));

    regfile_mp #(.DWIDTH(16), .RWIDTH(4), .NREAD(4), .ZERO_REG(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .re(re_b), .ra(ra_b), .rd(rd_b), .rd_pend(rd_pend_b),
        .we(we_b), .wa(wa_b), .wd(wd_b), .rsv_en(rsv_en_b), .rsv_a(rsv_a_b));

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] ma [64];
    logic        pa [64];
    logic [31:0] ea [2];
    logic        epa [2];
    logic [15:0] mb [16];
    logic        pb [16];
    logic [15:0] eb [4];
    logic        epb [4];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin ma[i] = '0; pa[i] = 1'b0; end
        for (int i = 0; i < 16; i++) begin mb[i] = '0; pb[i] = 1'b0; end
        for (int i = 0; i < 2; i++) begin ea[i] = '0; epa[i] = 1'b0; end
        for (int i = 0; i < 4; i++) begin eb[i] = '0; epb[i] = 1'b0; end
    endtask

    // One clock of traffic on instance A; the model follows the architectural rules.
    task automatic step_a(input logic [1:0] re, input logic [5:0] r0, input logic [5:0] r1,
                          input logic w, input logic [5:0] waddr, input logic [31:0] wdata,
                          input logic rv, input logic [5:0] raddr, input string tag);
        logic [5:0] ral [2];
        ral[0] = r0; ral[1] = r1;
        re_a = re; ra_a = {r1, r0}; we_a = w; wa_a = waddr; wd_a = wdata;
        rsv_en_a = rv; rsv_a_a = raddr;
        for (int i = 0; i < 2; i++) begin
            if (re[i]) begin
                if (ral[i] == 0) begin
                    ea[i] = '0; epa[i] = 1'b0;
                end else if (BYP && w && waddr == ral[i]) begin
                    ea[i] = wdata; epa[i] = rv && (raddr == ral[i]);
                end else begin
                    ea[i] = ma[ral[i]]; epa[i] = pa[ral[i]];
                end
            end
        end
        if (w && waddr != 0) begin ma[waddr] = wdata; pa[waddr] = 1'b0; end
        if (rv && raddr != 0) pa[raddr] = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_rd%0d", tag, i), {32'h0, rd_a[i*32 +: 32]}, {32'h0, ea[i]});
            check($sformatf("%s_pend%0d", tag, i), {63'h0, rd_pend_a[i]}, {63'h0, epa[i]});
        end
    endtask

    task automatic step_b(input logic [3:0] re, input logic [15:0] ra_all,
                          input logic w, input logic [3:0] waddr, input logic [15:0] wdata,
                          input logic rv, input logic [3:0] raddr, input string tag);
        logic [3:0] a;
        re_b = re; ra_b = ra_all; we_b = w; wa_b = waddr; wd_b = wdata;
        rsv_en_b = rv; rsv_a_b = raddr;
        for (int i = 0; i < 4; i++) begin
            a = ra_all[i*4 +: 4];
            if (re[i]) begin
                if (a == 0) begin
                    eb[i] = '0; epb[i] = 1'b0;
                end else if (BYP && w && waddr == a) begin
                    eb[i] = wdata; epb[i] = rv && (raddr == a);
                end else begin
                    eb[i] = mb[a]; epb[i] = pb[a];
                end
            end
        end
        if (w && waddr != 0) begin mb[waddr] = wdata; pb[waddr] = 1'b0; end
        if (rv && raddr != 0) pb[raddr] = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_rd%0d", tag, i), {48'h0, rd_b[i*16 +: 16]}, {48'h0, eb[i]});
            check($sformatf("%s_pend%0d", tag, i), {63'h0, rd_pend_b[i]}, {63'h0, epb[i]});
            if (re[i] && ra_all[i*4 +: 4] == 4'd0)
                check($sformatf("%s_zero%0d", tag, i), {48'h0, rd_b[i*16 +: 16]}, 64'h0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        re_a = '0; ra_a = '0; we_a = 1'b0; wa_a = '0; wd_a = '0; rsv_en_a = 1'b0; rsv_a_a = '0;
        re_b = '0; ra_b = '0; we_b = 1'b0; wa_b = '0; wd_b = '0; rsv_en_b = 1'b0; rsv_a_b = '0;
        model_reset();
        #2;
        check("por_rd_a", rd_a, 64'h0);
        check("por_pend_a", {62'h0, rd_pend_a}, 64'h0);
        check("por_rd_b", rd_b, 64'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset mid-operation
        step_a(2'b00, 6'd0, 6'd0, 1'b1, 6'd5, 32'hDEADBEEF, 1'b0, 6'd0, "rst_wr");
        step_a(2'b11, 6'd5, 6'd5, 1'b0, 6'd0, 32'h0, 1'b0, 6'd0, "rst_pre");
        #3 rst_n = 1'b0;
        #1;
        check("rst_async_rd", rd_a, 64'h0);
        check("rst_async_pend", {62'h0, rd_pend_a}, 64'h0);
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        step_a(2'b11, 6'd5, 6'd5, 1'b0, 6'd0, 32'h0, 1'b0, 6'd0, "rst_post");
        check("rst_post_reg5", rd_a, 64'h0);

        // Basic write then read, then hold
        step_a(2'b00, 6'd0, 6'd0, 1'b1, 6'd7, 32'h12345678, 1'b0, 6'd0, "basic_wr");
        step_a(2'b11, 6'd7, 6'd7, 1'b0, 6'd0, 32'h0, 1'b0, 6'd0, "basic_rd");
        check("basic_p0", {32'h0, rd_a[31:0]}, 64'h12345678);
        check("basic_p1", {32'h0, rd_a[63:32]}, 64'h12345678);
        step_a(2'b00, 6'd1, 6'd2, 1'b1, 6'd7, 32'h0BAD0BAD, 1'b0, 6'd0, "basic_hold");
        check("basic_hold_p0", {32'h0, rd_a[31:0]}, 64'h12345678);

        // Zero register
        step_a(2'b00, 6'd0, 6'd0, 1'b1, 6'd0, 32'hFFFFFFFF, 1'b1, 6'd0, "zero_wr");
        step_a(2'b11, 6'd0, 6'd0, 1'b0, 6'd0, 32'h0, 1'b0, 6'd0, "zero_rd");
        check("zero_rd_val", rd_a, 64'h0);
        check("zero_rd_pend", {62'h0, rd_pend_a}, 64'h0);

        // Scoreboard
        step_a(2'b00, 6'd0, 6'd0, 1'b0, 6'd0, 32'h0, 1'b1, 6'd3, "sb_rsv");
        step_a(2'b01, 6'd3, 6'd0, 1'b0, 6'd0, 32'h0, 1'b0, 6'd0, "sb_rd1");
        check("sb_pend_set", {63'h0, rd_pend_a[0]}, 64'h1);
        step_a(2'b00, 6'd0, 6'd0, 1'b1, 6'd3, 32'hA5A5A5A5, 1'b0, 6'd0, "sb_wr");
        step_a(2'b01, 6'd3, 6'd0, 1'b0, 6'd0, 32'h0, 1'b0, 6'd0, "sb_rd2");
        check("sb_pend_clr", {63'h0, rd_pend_a[0]}, 64'h0);
        check("sb_val", {32'h0, rd_a[31:0]}, 64'hA5A5A5A5);
        step_a(2'b00, 6'd0, 6'd0, 1'b1, 6'd3, 32'h00000055, 1'b1, 6'd3, "sb_wrrsv");
        step_a(2'b01, 6'd3, 6'd0, 1'b0, 6'd0, 32'h0, 1'b0, 6'd0, "sb_rd3");
        check("sb_rsv_wins", {63'h0, rd_pend_a[0]}, 64'h1);
        check("sb_wr_taken", {32'h0, rd_a[31:0]}, 64'h55);

        // Same-cycle write/read hazard
        step_a(2'b00, 6'd0, 6'd0, 1'b1, 6'd9, 32'h00000001, 1'b0, 6'd0, "hz_init");
        step_a(2'b01, 6'd9, 6'd0, 1'b1, 6'd9, 32'hCAFEF00D, 1'b0, 6'd0, "hz_rd");
`ifdef REGFILE_BYPASS_EN
        check("hz_val", {32'h0, rd_a[31:0]}, 64'hCAFEF00D);
`else
        check("hz_val", {32'h0, rd_a[31:0]}, 64'h1);
`endif

        // Random traffic on a narrow address window to provoke collisions
        for (int n = 0; n < 300; n++) begin
            step_a(2'($urandom_range(0, 3)), 6'($urandom_range(0, 11)), 6'($urandom_range(0, 11)),
                   1'($urandom_range(0, 1)), 6'($urandom_range(0, 11)), $urandom,
                   1'($urandom_range(0, 3) == 0), 6'($urandom_range(0, 11)), "rand_a");
        end
        re_a = '0; we_a = 1'b0; rsv_en_a = 1'b0;

        // Parameter sweep instance: fill, then random 4-port reads
        for (int r = 0; r < 16; r++)
            step_b(4'h0, 16'h0, 1'b1, 4'(r), 16'(r * 16'h0101), 1'b0, 4'd0, "sw_fill");
        for (int n = 0; n < 200; n++) begin
            step_b(4'hF, 16'($urandom), 1'($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)),
                   16'($urandom), 1'($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)), "sw_rd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port register file with registered reads, a hardwired zero register and a per-register pending scoreboard.
- Sits between the decode stage and the ALU in the 32-bit datapath and supplies operands to N read ports per cycle.
- Unlike the single-mode predecessor, reads and writes occur in the same cycle, and the block tracks in-flight destination registers so the issue logic can stall.

Parameters:
- DWIDTH, 32, data word width in bits.
- RWIDTH, 6, address width; depth is 2**RWIDTH.
- NREAD, 2, number of independent read ports, range 1..4.
- ZERO_REG, 1, when 1 register 0 reads as 0 and ignores writes and reservations.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- re  in  NREAD  per-port read enable
- ra  in  NREAD*RWIDTH  read addresses; port i uses bits [i*RWIDTH +: RWIDTH]
- rd  out  NREAD*DWIDTH  registered read data; port i uses bits [i*DWIDTH +: DWIDTH]
- rd_pend  out  NREAD  registered pending flag of the addressed register
- we  in  1  write enable
- wa  in  RWIDTH  write address
- wd  in  DWIDTH  write data
- rsv_en  in  1  reserve-destination strobe
- rsv_a  in  RWIDTH  register to mark pending

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset (rst_n=0, asynchronous):
  - All storage words clear to 0.
  - All pend bits clear to 0.
  - rd clears to 0 and rd_pend clears to 0.
  - Reset asserted mid-operation discards any in-flight write or reservation.
- Write: at posedge with we=1, Mem[wa] <= wd and pend[wa] <= 0.
- Reserve: at posedge with rsv_en=1, pend[rsv_a] <= 1.
- Simultaneous write and reserve to the same address: the reserve wins, so pend stays 1 and Mem still takes wd.
- Write and reserve to different addresses: both take effect independently.
- Read (latency 1):
  - At posedge with re[i]=1, rd[i] <= Mem[ra[i]] and rd_pend[i] <= pend[ra[i]], using the pre-edge values unless the optional bypass applies.
  - re[i]=0 holds rd[i] and rd_pend[i].
  - Ports are independent; any number may read the same address.
- Zero register (ZERO_REG=1):
  - Writes and reservations to address 0 are dropped.
  - Reads of address 0 return 0 with pend 0.
- Address range: all addresses are in range by construction; there is no wrap-around.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: a read of address A in the same cycle as we=1, wa=A returns wd, and rd_pend reflects the post-edge pend value. Example: a same-cycle write+reserve to A yields rd_pend=1; a write only yields rd_pend=0. The zero register is never bypassed.
- Undefined: same-cycle reads return the old Mem and pend values; the new value is visible one cycle later.

Decomposition:
- Package regfile_pkg holds:
  - default constants DWIDTH_DEF=32, RWIDTH_DEF=6, NREAD_MAX=4;
  - typedef word_t of logic [DWIDTH_DEF-1:0];
  - typedef raddr_t of logic [RWIDTH_DEF-1:0].
- Sub-module regfile_read_port:
  - one instance per read port via generate;
  - contains the address mux, zero-register masking, optional bypass compare and the rd/rd_pend output flops.
- Storage and the pend vector stay in regfile_mp.

Test Plan:
- Reset check: write 32'hDEADBEEF to reg 5, assert rst_n=0 mid-cycle, then read reg 5 on both ports. Required: rd=0 and rd_pend=0 immediately on reset assertion; after release, reads of reg 5 return 0.
- Basic write/read: write 32'h12345678 to reg 7, then next cycle read port0=7 and port1=7. Required: both ports show 32'h12345678 one cycle after re; holding re=0 keeps the value.
- Zero register: write 32'hFFFFFFFF to reg 0 and reserve reg 0. Required: a later read returns 0 with rd_pend=0.
- Scoreboard sequence:
  - Reserve reg 3, then read it. Required: rd_pend=1.
  - Write reg 3 with 32'hA5A5A5A5, then read next cycle. Required: rd_pend=0 and rd=32'hA5A5A5A5.
  - Write and reserve reg 3 in the same cycle. Required: pend stays 1.
- Same-cycle hazard: write 32'hCAFEF00D to reg 9 while port0 reads reg 9, where reg 9 previously held 32'h1. Required: returns 32'hCAFEF00D with REGFILE_BYPASS_EN defined, and 32'h1 without it.
- Parameter sweep: NREAD=4, RWIDTH=4, DWIDTH=16. Write regs 0..15 with their index times 16'h0101, then read random addresses on all 4 ports simultaneously for 200 cycles. Required: every read matches a scoreboard model, and reg 0 always reads 0.
